// File: rtl/imem_loader_pkg.sv
// Shared controller definitions: opcodes, loader error codes and FSM encoding.
// The decoder imports the same package so opcode values live in one place.
package imem_loader_pkg;

    localparam logic [3:0] OP_BLOCK_END      = 4'd8;
    localparam logic [3:0] OP_PU_BLOCK_START = 4'd10;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SIZE    = 2'd1;
    localparam logic [1:0] ERR_NO_LAST = 2'd2;
    localparam logic [1:0] ERR_EXTRA   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_START,
        S_WAIT_DONE,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/imem_prog_checker.sv
// Program structure tracker: skips PU payload spans, counts BLOCK_ENDs and
// flags a missing or non-final last BLOCK_END.
module imem_prog_checker
    import imem_loader_pkg::*;
#(
    parameter int INST_W    = 32,
    parameter int OP_CODE_W = 4,
    parameter int IMM_WIDTH = 16,
    parameter int CNT_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              word_v,
    input  logic [INST_W-1:0] word,
    output logic              last_seen,
    output logic              extra,
    output logic [CNT_W-1:0]  num_blocks
);

    logic [IMM_WIDTH:0]     pu_left;
    logic [OP_CODE_W-1:0]   op;
    logic [IMM_WIDTH-1:0]   imm;
    logic                   unused_mid;

    assign op         = word[INST_W-1 -: OP_CODE_W];
    assign imm        = word[IMM_WIDTH-1:0];
    assign unused_mid = ^word[INST_W-OP_CODE_W-1:IMM_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pu_left    <= '0;
            last_seen  <= 1'b0;
            extra      <= 1'b0;
            num_blocks <= '0;
        end else if (clear) begin
            pu_left    <= '0;
            last_seen  <= 1'b0;
            extra      <= 1'b0;
            num_blocks <= '0;
        end else if (word_v) begin
            if (pu_left != '0) begin
                pu_left <= pu_left - 1'b1;
            end else begin
                if (last_seen)
                    extra <= 1'b1;
                // span counter is one bit wider than imm so N=0xFFFF yields 0x10000
                if (op == OP_CODE_W'(OP_PU_BLOCK_START)) begin
                    pu_left <= {1'b0, imm} + 1'b1;
                end else if (op == OP_CODE_W'(OP_BLOCK_END)) begin
                    if (num_blocks != '1)
                        num_blocks <= num_blocks + 1'b1;
                    if (imm[0])
                        last_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: writes a host program from address 0, validates
// its structure, then launches the decoder and reports completion.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_ADDR_W = 10,
    parameter int INST_W      = 32,
    parameter int OP_CODE_W   = 4,
    parameter int IMM_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_v,
    input  logic [IMEM_ADDR_W:0]   load_num_inst,
    output logic                   load_ready,
    input  logic [INST_W-1:0]      inst_data,
    input  logic                   inst_valid,
    output logic                   inst_ready,
    output logic                   imem_write_req,
    output logic [IMEM_ADDR_W-1:0] imem_write_addr,
    output logic [INST_W-1:0]      imem_write_data,
    output logic                   start,
    input  logic                   done,
    output logic                   prog_done,
    output logic                   prog_err,
    output logic [1:0]             err_code,
    output logic [IMEM_ADDR_W-1:0] num_blocks
);

    localparam logic [IMEM_ADDR_W:0] MAX_SIZE = {1'b1, {IMEM_ADDR_W{1'b0}}};

    state_t               state, state_nx;
    logic [IMEM_ADDR_W:0] size, cnt;
    logic                 cmd_acc, word_acc, bad_size, last_word;
    logic                 last_seen, extra;

    assign cmd_acc   = load_v && load_ready;
    assign word_acc  = inst_valid && inst_ready;
    assign bad_size  = (load_num_inst == '0) || (load_num_inst > MAX_SIZE);
    assign last_word = word_acc && (cnt == size - 1'b1);

    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        inst_ready = 1'b0;
        start      = 1'b0;
        prog_done  = 1'b0;
        case (state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_v)
                    state_nx = bad_size ? S_ERROR : S_LOAD;
            end
            S_LOAD: begin
                inst_ready = 1'b1;
                if (last_word)
                    state_nx = S_CHECK;
            end
            S_CHECK:     state_nx = (extra || !last_seen) ? S_ERROR : S_START;
            S_START: begin
                start    = 1'b1;
                state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: if (done) state_nx = S_DONE;
            S_DONE: begin
                prog_done = 1'b1;
                state_nx  = S_IDLE;
            end
            S_ERROR:     state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            size            <= '0;
            cnt             <= '0;
            prog_err        <= 1'b0;
            err_code        <= ERR_NONE;
            imem_write_req  <= 1'b0;
            imem_write_addr <= '0;
            imem_write_data <= '0;
        end else begin
            state          <= state_nx;
            imem_write_req <= word_acc;
            if (word_acc) begin
                imem_write_addr <= cnt[IMEM_ADDR_W-1:0];
                imem_write_data <= inst_data;
                cnt             <= cnt + 1'b1;
            end
            if (cmd_acc) begin
                size     <= load_num_inst;
                cnt      <= '0;
                prog_err <= 1'b0;
                err_code <= bad_size ? ERR_SIZE : ERR_NONE;
            end
            // later assignment wins over the clear above for a rejected command
            if (state_nx == S_ERROR)
                prog_err <= 1'b1;
            if (state == S_CHECK)
                err_code <= extra ? ERR_EXTRA : (!last_seen ? ERR_NO_LAST : ERR_NONE);
        end
    end

    imem_prog_checker #(
        .INST_W    (INST_W),
        .OP_CODE_W (OP_CODE_W),
        .IMM_WIDTH (IMM_WIDTH),
        .CNT_W     (IMEM_ADDR_W)
    ) u_checker (
        .clk        (clk),
        .reset      (reset),
        .clear      (cmd_acc),
        .word_v     (word_acc),
        .word       (inst_data),
        .last_seen  (last_seen),
        .extra      (extra),
        .num_blocks (num_blocks)
    );

endmodule
